// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   DEF_N_REQ / DEF_WIDTH / DEF_DEPTH / DEF_CNT_W : default parameter values
//   CRED_W  : width of the credit counter for the default depth
//   GIDX_W  : width of a requester index for the default requester count
//   onehot(): index -> one-hot vector, truncated by the caller to N_REQ bits
package fifo_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 16;

  localparam int CRED_W = $clog2(DEF_DEPTH) + 1;
  localparam int GIDX_W = $clog2(DEF_N_REQ);

  // Widest requester vector onehot() can describe.
  localparam int MAX_REQ = 32;

  function automatic logic [MAX_REQ-1:0] onehot(input int idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin picker.
//   eligible : per-requester candidate mask
//   last_gnt : index granted most recently; search starts just after it
//   valid    : at least one requester is eligible
//   winner   : first eligible index from last_gnt+1 upward, wrapping
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] last_gnt,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [N_REQ-1:0] rotated;
  int               start_idx;

  // Rotate the request mask so bit 0 is the highest-priority requester;
  // a shift of N_REQ (last_gnt = N_REQ-1) rotates back to the original order.
  // NOTE: every output gets a default before the search so no path infers a latch.
  always_comb begin
    start_idx = int'(last_gnt) + 1;
    rotated   = N_REQ'({eligible, eligible} >> start_idx);
    valid     = 1'b0;
    winner    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid && rotated[i]) begin
        valid  = 1'b1;
        winner = IDX_W'((start_idx + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among N_REQ
// requesters, with credit-based flow control so the FIFO is never written
// when full.
//   clk, rst   : clock, asynchronous active-low reset
//   req        : per-requester valid, held until its ack is seen
//   req_data   : requester i data in bits [i*WIDTH +: WIDTH]
//   ack        : registered one-hot pulse, requester's word was written
//   fifo_wr    : registered FIFO write strobe
//   fifo_din   : registered FIFO write data (holds when idle)
//   fifo_pop   : consumer removed one entry this cycle
//   credit     : free FIFO entries as seen by the arbiter
//   gnt_cnt    : per-requester grant counters (only with ARB_STATS_EN)
// Build option: define ARB_STATS_EN to add the gnt_cnt counters and port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int CNT_W     = DEF_CNT_W,
  localparam int CRED_BITS = $clog2(DEPTH) + 1,
  localparam int IDX_BITS  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic                   fifo_wr,
  output logic [WIDTH-1:0]       fifo_din,
  input  logic                   fifo_pop,
  output logic [CRED_BITS-1:0]   credit
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0] gnt_cnt
`endif
);

  localparam logic [CRED_BITS-1:0] CRED_MAX = CRED_BITS'(DEPTH);

  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 fifo_wr_q, fifo_wr_d;
  logic [WIDTH-1:0]     fifo_din_q, fifo_din_d;
  logic [CRED_BITS-1:0] credit_q, credit_d;
  logic [IDX_BITS-1:0]  last_gnt_q, last_gnt_d;

  logic [N_REQ-1:0]     eligible;
  logic                 arb_valid;
  logic [IDX_BITS-1:0]  winner;
  logic                 issue;
  logic [WIDTH-1:0]     win_data;

  // A requester acked this cycle still shows its old word; mask it so the
  // same word is never written twice.
  assign eligible = req & ~ack_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_BITS)
  ) u_rr (
    .eligible (eligible),
    .last_gnt (last_gnt_q),
    .valid    (arb_valid),
    .winner   (winner)
  );

  // Only the registered credit gates issue; a pop in the same cycle is
  // credited at the edge, never spent early.
  assign issue = arb_valid && (credit_q != '0);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDX_BITS'(i)) begin
        win_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Issue and pop together leave credit unchanged; a pop at full credit is
  // illegal upstream and is simply ignored.
  always_comb begin
    credit_d = credit_q;
    if (issue && !fifo_pop) begin
      credit_d = credit_q - CRED_BITS'(1);
    end else if (!issue && fifo_pop && (credit_q != CRED_MAX)) begin
      credit_d = credit_q + CRED_BITS'(1);
    end
  end

  always_comb begin
    ack_d      = '0;
    fifo_wr_d  = 1'b0;
    fifo_din_d = fifo_din_q;
    last_gnt_d = last_gnt_q;
    if (issue) begin
      ack_d      = N_REQ'(onehot(int'(winner)));
      fifo_wr_d  = 1'b1;
      fifo_din_d = win_data;
      last_gnt_d = winner;
    end
  end

  // last_gnt resets to the top index so requester 0 wins the first grant.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q      <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_din_q <= '0;
      credit_q   <= CRED_MAX;
      last_gnt_q <= IDX_BITS'(N_REQ - 1);
    end else begin
      ack_q      <= ack_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_din_q <= fifo_din_d;
      credit_q   <= credit_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign ack      = ack_q;
  assign fifo_wr  = fifo_wr_q;
  assign fifo_din = fifo_din_q;
  assign credit   = credit_q;

`ifdef ARB_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      gnt_cnt_d[i] = gnt_cnt_q[i] + CNT_W'(ack_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign gnt_cnt = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8, DEPTH=8).
// A behavioural model tracks expected ack/fifo_wr/fifo_din/credit (and
// gnt_cnt with ARB_STATS_EN) and is compared every cycle on the falling
// edge; directed scenarios add literal expectations, then a randomized
// phase drives requesters and a consumer that respect the protocol.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req;
  logic [W-1:0]  rd [N];
  logic [N*W-1:0] req_data;
  logic [N-1:0]  ack;
  logic          fifo_wr;
  logic [W-1:0]  fifo_din;
  logic          fifo_pop;
  logic [CW-1:0] credit;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] gnt_cnt;
`endif

  assign req_data = {rd[3], rd[2], rd[1], rd[0]};

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .fifo_wr  (fifo_wr),
    .fifo_din (fifo_din),
    .fifo_pop (fifo_pop),
    .credit   (credit)
`ifdef ARB_STATS_EN
    ,
    .gnt_cnt  (gnt_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_credit;
  int         m_last;
  int         m_ack;   // index acked this cycle, -1 for none
  int         m_occ;   // entries actually inside the FIFO
  bit         m_wr;
  logic [7:0] m_din;
  int         m_cnt [N];

  always @(posedge clk or negedge rst) begin
    int win;
    int nc;
    int no;
    int idx;
    bit iss;
    if (!rst) begin
      m_credit <= D;
      m_last   <= N - 1;
      m_ack    <= -1;
      m_occ    <= 0;
      m_wr     <= 1'b0;
      m_din    <= 8'h00;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else begin
      win = -1;
      for (int off = 1; off <= N; off++) begin
        idx = (m_last + off) % N;
        if (win < 0 && req[idx] && m_ack != idx) win = idx;
      end
      iss = (win >= 0) && (m_credit > 0);
      nc  = m_credit - (iss ? 1 : 0) + (fifo_pop ? 1 : 0);
      if (nc > D) nc = D;
      no  = m_occ + (m_wr ? 1 : 0) - (fifo_pop ? 1 : 0);
      if (no < 0) no = 0;
      if (m_ack >= 0) m_cnt[m_ack] <= (m_cnt[m_ack] + 1) % 65536;
      m_credit <= nc;
      m_occ    <= no;
      m_wr     <= iss;
      m_ack    <= iss ? win : -1;
      if (iss) begin
        m_din  <= rd[win];
        m_last <= win;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] exp_ack;
    if (cmp_en && rst) begin
      exp_ack = (m_ack >= 0) ? N'(1 << m_ack) : '0;
      check("cyc_ack", 64'(ack), 64'(exp_ack));
      check("cyc_fifo_wr", 64'(fifo_wr), 64'(m_wr));
      check("cyc_fifo_din", 64'(fifo_din), 64'(m_din));
      check("cyc_credit", 64'(credit), 64'(m_credit));
`ifdef ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
        check("cyc_gnt_cnt", 64'(gnt_cnt[i*16 +: 16]), 64'(m_cnt[i]));
      end
`endif
    end
  end

  // ---------------- helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req      = '0;
    fifo_pop = 1'b0;
    for (int i = 0; i < N; i++) rd[i] = 8'h00;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic load_a_words();
    for (int i = 0; i < N; i++) rd[i] = 8'hA0 + 8'(i);
  endtask

  logic [7:0] q [N][$];
  int         wr_cnt;

  initial begin
    req      = '0;
    fifo_pop = 1'b0;
    for (int i = 0; i < N; i++) rd[i] = 8'h00;

    // Reset values
    #2 rst = 1'b0;
    #1;
    check("rst_credit", 64'(credit), 64'd8);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_fifo_wr", 64'(fifo_wr), 64'd0);
    check("rst_fifo_din", 64'(fifo_din), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    cmp_en = 1'b1;

    // 1. Single requester, stale request held through the ack cycle
    req   = 4'b0001;
    rd[0] = 8'h11;
    next_cycle();
    check("t1_fifo_wr", 64'(fifo_wr), 64'd1);
    check("t1_fifo_din", 64'(fifo_din), 64'h11);
    check("t1_ack", 64'(ack), 64'b0001);
    check("t1_credit", 64'(credit), 64'd7);
    next_cycle();
    check("t1_no_regrant_wr", 64'(fifo_wr), 64'd0);
    check("t1_no_regrant_ack", 64'(ack), 64'd0);
    check("t1_din_held", 64'(fifo_din), 64'h11);
    req = '0;

    // 2. All requesters, consumer pops whenever the FIFO holds data
    apply_reset();
    load_a_words();
    req = 4'hF;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      check("t2_ack_order", 64'(ack), 64'(4'b0001 << (c % 4)));
      check("t2_din", 64'(fifo_din), 64'(8'hA0 + 8'(c % 4)));
      check("t2_wr_every_cycle", 64'(fifo_wr), 64'd1);
      check("t2_credit_ge6", 64'(credit >= 6), 64'd1);
      fifo_pop = (m_occ > 0);
    end
    req      = '0;
    fifo_pop = 1'b0;

    // 3. Fill without pops, then a single pop releases one write
    apply_reset();
    load_a_words();
    req    = 4'hF;
    wr_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      if (fifo_wr) wr_cnt++;
    end
    check("t3_wr_pulses", 64'(wr_cnt), 64'd8);
    check("t3_credit_empty", 64'(credit), 64'd0);
    check("t3_wr_stopped", 64'(fifo_wr), 64'd0);
    fifo_pop = 1'b1;
    next_cycle();
    fifo_pop = 1'b0;
    check("t3_pop_credit", 64'(credit), 64'd1);
    check("t3_pop_no_wr_yet", 64'(fifo_wr), 64'd0);
    next_cycle();
    check("t3_refill_wr", 64'(fifo_wr), 64'd1);
    check("t3_refill_credit", 64'(credit), 64'd0);
    next_cycle();
    check("t3_single_wr", 64'(fifo_wr), 64'd0);

    // 4. Issue and pop in the same cycle at credit 3; pop at full credit
    req      = '0;
    fifo_pop = 1'b1;
    for (int c = 0; c < 3; c++) next_cycle();
    check("t4_credit3", 64'(credit), 64'd3);
    req = 4'b0001;
    next_cycle();
    check("t4_issue_pop_credit", 64'(credit), 64'd3);
    check("t4_issue_pop_wr", 64'(fifo_wr), 64'd1);
    req      = '0;
    fifo_pop = 1'b0;
    apply_reset();
    fifo_pop = 1'b1;
    next_cycle();
    fifo_pop = 1'b0;
    check("t4_pop_at_full", 64'(credit), 64'd8);

    // 5. Reset between edges in the middle of a burst
    apply_reset();
    load_a_words();
    req      = 4'hF;
    fifo_pop = 1'b0;
    for (int c = 0; c < 3; c++) next_cycle();
    #3 rst = 1'b0;
    #1;
    check("t5_wr_drop", 64'(fifo_wr), 64'd0);
    check("t5_ack_drop", 64'(ack), 64'd0);
    check("t5_din_drop", 64'(fifo_din), 64'd0);
    check("t5_credit", 64'(credit), 64'd8);
    @(posedge clk);
    #1 rst = 1'b1;
    next_cycle();
    check("t5_first_grant", 64'(ack), 64'b0001);
    check("t5_first_din", 64'(fifo_din), 64'hA0);
    req = '0;

`ifdef ARB_STATS_EN
    // 6. Twelve round-robin grants -> three per requester
    apply_reset();
    load_a_words();
    req = 4'hF;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      fifo_pop = (m_occ > 0);
    end
    req = '0;
    next_cycle();
    fifo_pop = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("t6_gnt_cnt", 64'(gnt_cnt[i*16 +: 16]), 64'd3);
    end
`endif

    // Randomized requesters and consumer
    apply_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    for (int c = 0; c < 1600; c++) begin
      next_cycle();
      for (int i = 0; i < N; i++) begin
        if (m_ack == i && q[i].size() != 0) void'(q[i].pop_front());
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0) q[i].push_back(8'($urandom));
        req[i] = (q[i].size() != 0);
        rd[i]  = req[i] ? q[i][0] : 8'h00;
      end
      if (c < 800) fifo_pop = (m_occ > 0) && ($urandom_range(0, 3) == 0);
      else         fifo_pop = (m_occ > 0) && ($urandom_range(0, 3) != 0);
    end
    req      = '0;
    fifo_pop = 1'b0;
    next_cycle();
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
